// File: rtl/pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_pkg
// Shared types and helpers for the pulse stretcher slice.
//   state_t  : FSM state encoding (IDLE, HIGH, GAP), 2 bits
//   eff_len  : effective pulse length, max(len,1)
//   pend_max : largest value a PEND_W-bit pending counter may hold
// -----------------------------------------------------------------------------
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // A requested length of 0 still produces a one-cycle pulse.
  function automatic logic [31:0] eff_len(input logic [31:0] l);
    return (l == '0) ? 32'd1 : l;
  endfunction

  function automatic int pend_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// -----------------------------------------------------------------------------
// sat_updown_cnt
// Saturating up/down counter used to track queued triggers.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset, clears the count
//   inc     : count up by one (held at the maximum if already full)
//   dec     : count down by one (held at zero if already empty)
//   cnt     : registered count
//   cnt_nxt : value cnt takes at the next edge
//   sat_hit : an increment was refused because the counter is full
// Simultaneous inc and dec cancel and never report a saturation hit.
// -----------------------------------------------------------------------------
module sat_updown_cnt
  import pulse_stretcher_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         sat_hit
);

  localparam logic [W-1:0] MAX = W'(pend_max(W));

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    cnt_nxt = cnt;
    sat_hit = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (cnt == MAX) sat_hit = 1'b1;
        else            cnt_nxt = cnt + W'(1);
      end
      2'b01: begin
        if (cnt != '0) cnt_nxt = cnt - W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
// Turns single-cycle trigger strobes into level pulses of programmable length,
// with a guaranteed low gap between pulses and a bounded trigger queue.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   trig : trigger strobe, sampled every rising edge
//   len  : pulse length in cycles (0 acts as 1), sampled when a pulse starts
//   out  : stretched pulse, registered
//   busy : registered, high while a pulse or gap is active or triggers queued
//   pend : number of queued triggers
//   ovf  : sticky, set when a trigger is dropped on a full queue
//
// Parameters: LEN_W (length width), GAP (low cycles between pulses, 1..255),
// PEND_W (pending counter width, queue depth 2^PEND_W-1).
//
// Build option PULSE_STRETCHER_RETRIG_EN: retrigger mode. A trigger during
// HIGH reloads the length (extending the pulse), a trigger during GAP starts
// a new pulse at once, and the queue stays empty.
// -----------------------------------------------------------------------------
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int GAP    = 2,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [LEN_W-1:0]  len,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_cnt, len_cnt_nxt, len_load;
  logic [7:0]         gap_cnt, gap_cnt_nxt;
  logic               pend_inc, pend_dec, sat_hit;
  logic [PEND_W-1:0]  pend_nxt;

  // Counter counts down to 0, so it is loaded with the length minus one.
  assign len_load = LEN_W'(eff_len(32'(len)) - 32'd1);

  always_comb begin
    state_nxt   = state;
    len_cnt_nxt = len_cnt;
    gap_cnt_nxt = gap_cnt;
    pend_inc    = 1'b0;
    pend_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nxt   = ST_HIGH;
          len_cnt_nxt = len_load;
        end
      end
`ifdef PULSE_STRETCHER_RETRIG_EN
      ST_HIGH: begin
        if (trig) begin
          len_cnt_nxt = len_load;
        end else if (len_cnt == '0) begin
          state_nxt   = ST_GAP;
          gap_cnt_nxt = GAP_LOAD;
        end else begin
          len_cnt_nxt = len_cnt - LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (trig) begin
          state_nxt   = ST_HIGH;
          len_cnt_nxt = len_load;
        end else if (gap_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end
`else
      ST_HIGH: begin
        pend_inc = trig;
        if (len_cnt == '0) begin
          state_nxt   = ST_GAP;
          gap_cnt_nxt = GAP_LOAD;
        end else begin
          len_cnt_nxt = len_cnt - LEN_W'(1);
        end
      end
      ST_GAP: begin
        pend_inc = trig;
        if (gap_cnt == '0) begin
          if (pend != '0 || trig) begin
            state_nxt   = ST_HIGH;
            len_cnt_nxt = len_load;
            // A queued trigger is consumed; with an empty queue the live
            // trigger starts the pulse itself instead of being queued.
            if (pend != '0) pend_dec = 1'b1;
            else            pend_inc = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  sat_updown_cnt #(.W(PEND_W)) u_pend_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (pend_inc),
    .dec     (pend_dec),
    .cnt     (pend),
    .cnt_nxt (pend_nxt),
    .sat_hit (sat_hit)
  );

  // Outputs are registered from next-state values so they line up with the
  // state register and never see a combinational path from trig or len.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      len_cnt <= '0;
      gap_cnt <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      len_cnt <= len_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      out     <= (state_nxt == ST_HIGH);
      busy    <= (state_nxt != ST_IDLE) | (pend_nxt != '0);
      ovf     <= ovf | sat_hit;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
// Directed stimulus pushes the expected pulse (length, preceding low gap) into
// a scoreboard queue; a negedge monitor measures every output pulse and
// compares it against the queue head. Queue/flag state is checked directly
// at chosen cycles. Instantiated with PEND_W=2 so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

  localparam int LEN_W  = 8;
  localparam int GAP    = 2;
  localparam int PEND_W = 2;

  typedef struct {
    int len;
    int gap;   // -1: pulse follows idle, gap not checked
  } exp_pulse_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              trig = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pend;
  logic              ovf;

  int checks = 0;
  int errors = 0;
  exp_pulse_t sb[$];

  pulse_stretcher #(.LEN_W(LEN_W), .GAP(GAP), .PEND_W(PEND_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .trig (trig),
    .len  (len),
    .out  (out),
    .busy (busy),
    .pend (pend),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    if (GAP < 1) begin
      $display("FAIL gap_param actual=%0d required>=1", GAP);
      $fatal(1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input int l, input int g);
    exp_pulse_t e;
    e.len = l;
    e.gap = g;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    trig = 1'b0;
    #1;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pend, 0);
    check("rst_ovf", ovf, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  // Monitor: measures pulse width and preceding low gap on the opposite edge.
  exp_pulse_t cur;
  int  hi_cnt   = 0;
  int  lo_cnt   = 1000;
  bit  in_pulse = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      in_pulse = 1'b0;
      hi_cnt   = 0;
      lo_cnt   = 1000;
      cur.len  = -1;
      cur.gap  = -1;
    end else if (out && !in_pulse) begin
      check("pulse_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        if (cur.gap >= 0) check("pulse_gap", lo_cnt, cur.gap);
      end else begin
        cur.len = -1;
        cur.gap = -1;
      end
      in_pulse = 1'b1;
      hi_cnt   = 1;
    end else if (out) begin
      hi_cnt++;
    end else if (in_pulse) begin
      if (cur.len >= 0) check("pulse_len", hi_cnt, cur.len);
      in_pulse = 1'b0;
      lo_cnt   = 1;
    end else begin
      lo_cnt++;
    end
  end

  initial begin
    do_reset();

    // Single trigger, len=5: 5 high cycles, busy drops GAP cycles later.
    expect_pulse(5, -1);
    len = 8'd5; trig = 1'b1;
    tick();
    trig = 1'b0;
    check("t1_out_start", out, 1);
    check("t1_busy_start", busy, 1);
    check("t1_pend", pend, 0);
    tick(5);
    check("t1_out_end", out, 0);
    check("t1_busy_gap", busy, 1);
    tick(2);
    check("t1_busy_end", busy, 0);

    // len=0 acts as 1.
    expect_pulse(1, -1);
    len = 8'd0; trig = 1'b1;
    tick();
    trig = 1'b0;
    tick(6);
    check("t2_busy_end", busy, 0);

`ifdef PULSE_STRETCHER_RETRIG_EN
    // Retrigger: len=4, triggers at cycles 0 and 2 give one 6-cycle pulse.
    do_reset();
    expect_pulse(6, -1);
    len = 8'd4; trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("rt_pend", pend, 0);
    tick(3);
    check("rt_out_last", out, 1);
    tick();
    check("rt_out_low", out, 0);
    tick(2);
    check("rt_busy_end", busy, 0);
    check("rt_ovf", ovf, 0);
`else
    // Three back-to-back triggers, len=3.
    do_reset();
    expect_pulse(3, -1);
    expect_pulse(3, GAP);
    expect_pulse(3, GAP);
    len = 8'd3; trig = 1'b1;
    tick();
    tick();
    check("t3_pend_a", pend, 1);
    tick();
    trig = 1'b0;
    check("t3_pend_b", pend, 2);
    tick(3);
    check("t3_pend_c", pend, 1);
    tick(5);
    check("t3_pend_d", pend, 0);
    tick(5);
    check("t3_busy_end", busy, 0);
    check("t3_ovf", ovf, 0);

    // Saturation: five triggers during one 8-cycle pulse, queue depth 3.
    do_reset();
    expect_pulse(8, -1);
    expect_pulse(8, GAP);
    expect_pulse(8, GAP);
    expect_pulse(8, GAP);
    len = 8'd8; trig = 1'b1;
    tick();
    tick(4);
    trig = 1'b0;
    check("t4_pend_sat", pend, 3);
    check("t4_ovf_set", ovf, 1);
    tick(36);
    check("t4_busy_end", busy, 0);
    check("t4_pend_end", pend, 0);
    check("t4_ovf_sticky", ovf, 1);

    // Trigger on the final GAP cycle, empty queue: restart after exactly GAP.
    do_reset();
    expect_pulse(2, -1);
    expect_pulse(2, GAP);
    len = 8'd2; trig = 1'b1;
    tick();
    trig = 1'b0;
    tick(3);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("t5a_out", out, 1);
    check("t5a_pend", pend, 0);
    tick(4);
    check("t5a_busy_end", busy, 0);

    // Same, with one trigger already queued: pend holds through the restart.
    expect_pulse(2, -1);
    expect_pulse(2, GAP);
    expect_pulse(2, GAP);
    trig = 1'b1;
    tick();
    tick();
    trig = 1'b0;
    check("t5b_pend_q", pend, 1);
    tick(2);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("t5b_out", out, 1);
    check("t5b_pend_hold", pend, 1);
    tick(4);
    check("t5b_pend_drain", pend, 0);
    tick(4);
    check("t5b_busy_end", busy, 0);

    // Reset mid-HIGH with two queued: output drops at once, queue discarded.
    do_reset();
    expect_pulse(10, -1);
    len = 8'd10; trig = 1'b1;
    tick(3);
    trig = 1'b0;
    check("t6_pend_pre", pend, 2);
    tick();
    rst = 1'b0;
    #1;
    check("t6_out_async", out, 0);
    check("t6_pend_clr", pend, 0);
    check("t6_busy_clr", busy, 0);
    tick(2);
    rst = 1'b1;
    tick(30);
    check("t6_busy_after", busy, 0);
`endif

    tick(2);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
